// File: rtl/rgb_pwm_pkg.sv
// rgb_pwm shared types.
// Channel modes and a width helper.
package rgb_pwm_pkg;

  typedef enum logic [1:0] {
    MODE_OFF     = 2'd0,
    MODE_STATIC  = 2'd1,
    MODE_BLINK   = 2'd2,
    MODE_BREATHE = 2'd3
  } mode_t;

  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rgb_pwm_chan.sv
// rgb_pwm single channel.
// Mode/duty state, breathe ramp and output flop.
module rgb_pwm_chan
  import rgb_pwm_pkg::*;
#(
  parameter int WIDTH  = 8,
  parameter bit INVERT = 1'b0
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [WIDTH-1:0] pwm_cnt,
  input  logic             period_end,
  input  logic             blink_phase,
  input  logic             apply,
  input  mode_t            new_mode,
  input  logic [WIDTH-1:0] new_duty,
  output logic             led
);

  mode_t            mode;
  logic [WIDTH-1:0] duty;
  logic [WIDTH-1:0] level;
  logic             dir_up;
  logic [WIDTH-1:0] lvl_inc;
  logic [WIDTH-1:0] lvl_dec;
  logic [WIDTH-1:0] lvl_step;
  logic             dir_step;
  logic [WIDTH-1:0] lvl;

  assign lvl_inc = level + 1'b1;
  assign lvl_dec = level - 1'b1;

  // Direction flips on the step that lands on duty or on zero.
  always_comb begin
    lvl_step = level;
    dir_step = dir_up;
    if (duty == '0) begin
      lvl_step = '0;
      dir_step = 1'b1;
    end else if ((dir_up && (level < duty)) ||
                 (level == '0)) begin
      lvl_step = lvl_inc;
      dir_step = (lvl_inc != duty);
    end else begin
      lvl_step = lvl_dec;
      dir_step = (lvl_dec == '0);
    end
  end

  always_comb begin
    lvl = '0;
    unique case (mode)
      MODE_OFF:     lvl = '0;
      MODE_STATIC:  lvl = duty;
      MODE_BLINK:   lvl = blink_phase ? duty : '0;
      MODE_BREATHE: lvl = level;
      default:      lvl = '0;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      mode   <= MODE_OFF;
      duty   <= '0;
      level  <= '0;
      dir_up <= 1'b1;
      led    <= INVERT;
    end else begin
      led <= (pwm_cnt < lvl) ^ INVERT;
      if (apply) begin
        mode <= new_mode;
        duty <= new_duty;
        if (new_mode == MODE_BREATHE) begin
          if (mode != MODE_BREATHE) begin
            level  <= '0;
            dir_up <= 1'b1;
          end else if (level > new_duty) begin
            level <= new_duty;
          end
        end
      end else if (period_end &&
                   (mode == MODE_BREATHE)) begin
        level  <= lvl_step;
        dir_up <= dir_step;
      end
    end
  end

endmodule

// File: rtl/rgb_pwm.sv
// rgb_pwm multi-channel PWM LED driver.
// Timebase, blink counter and the config slot.
module rgb_pwm
  import rgb_pwm_pkg::*;
#(
  parameter int CHANNELS      = 3,
  parameter int WIDTH         = 8,
  parameter int PRESCALE      = 16,
  parameter int BLINK_PERIODS = 64,
  parameter bit INVERT        = 1'b0
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic                        cfg_valid,
  output logic                        cfg_ready,
  input  logic [idx_w(CHANNELS)-1:0]  cfg_chan,
  input  logic [1:0]                  cfg_mode,
  input  logic [WIDTH-1:0]            cfg_duty,
  output logic                        cfg_err,
  output logic                        period_start,
  output logic [CHANNELS-1:0]         led_out
);

  localparam int CW = idx_w(CHANNELS);
  localparam int PW = idx_w(PRESCALE);
  localparam int BW = idx_w(BLINK_PERIODS);
  localparam logic [PW-1:0] PS_LAST = PW'(PRESCALE - 1);
  localparam logic [BW-1:0] BL_LAST = BW'(BLINK_PERIODS - 1);
  localparam logic [CW:0]   CH_LIM  = (CW + 1)'(CHANNELS);

  logic [PW-1:0]    presc;
  logic             tick;
  logic [WIDTH-1:0] pwm_cnt;
  logic             period_end;
  logic [BW-1:0]    blink_cnt;
  logic             blink_phase;
  logic             pend_full;
  logic [CW-1:0]    pend_chan;
  mode_t            pend_mode;
  logic [WIDTH-1:0] pend_duty;
  logic             xfer;
  logic             chan_ok;
  logic             apply_any;

  assign tick       = (presc == PS_LAST);
  assign period_end = tick && (pwm_cnt == '1);
  assign cfg_ready  = !pend_full;
  assign xfer       = cfg_valid && cfg_ready;
  assign chan_ok    = ({1'b0, cfg_chan} < CH_LIM);
  assign apply_any  = period_end && pend_full;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      presc        <= '0;
      pwm_cnt      <= '0;
      period_start <= 1'b0;
    end else begin
      presc        <= tick ? '0 : presc + 1'b1;
      period_start <= period_end;
      if (tick) pwm_cnt <= pwm_cnt + 1'b1;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      blink_cnt   <= '0;
      blink_phase <= 1'b1;
    end else if (period_end) begin
      if (blink_cnt == BL_LAST) begin
        blink_cnt   <= '0;
        blink_phase <= ~blink_phase;
      end else begin
        blink_cnt <= blink_cnt + 1'b1;
      end
    end
  end

  // Slot is only refilled while empty, so a write
  // landing on a period end waits a full period.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      pend_full <= 1'b0;
      pend_chan <= '0;
      pend_mode <= MODE_OFF;
      pend_duty <= '0;
      cfg_err   <= 1'b0;
    end else begin
      cfg_err <= xfer && !chan_ok;
      if (xfer && chan_ok) begin
        pend_full <= 1'b1;
        pend_chan <= cfg_chan;
        pend_mode <= mode_t'(cfg_mode);
        pend_duty <= cfg_duty;
      end else if (apply_any) begin
        pend_full <= 1'b0;
      end
    end
  end

  for (genvar i = 0; i < CHANNELS; i++) begin : g_chan
    rgb_pwm_chan #(
      .WIDTH  (WIDTH),
      .INVERT (INVERT)
    ) u_chan (
      .clock       (clock),
      .reset       (reset),
      .pwm_cnt     (pwm_cnt),
      .period_end  (period_end),
      .blink_phase (blink_phase),
      .apply       (apply_any && (pend_chan == CW'(i))),
      .new_mode    (pend_mode),
      .new_duty    (pend_duty),
      .led         (led_out[i])
    );
  end

endmodule
